// File: rtl/anita3_trig_scheduler.sv
// Trigger-time scheduler: queues absolute trigger times and arms the timebase comparator
// one PPS second at a time, reporting each head entry as fired or missed.
module anita3_trig_scheduler #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk250_i,
    input  logic                     rst_n_i,
    input  logic                     pps_i,
    input  logic                     enable_i,
    input  logic                     flush_i,
    input  logic                     wr_i,
    input  logic [31:0]              wr_time_i,
    input  logic                     trig_i,
    output logic [31:0]              trig_time_o,
    output logic                     trig_en_o,
    output logic                     fired_o,
    output logic                     missed_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StArmed
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    trig_time_q, trig_time_d;
    logic           fired_q, fired_d;
    logic           missed_q, missed_d;
    logic           overflow_q, overflow_d;
    logic           full, push, pop;
    logic [31:0]    head_d;

    always_comb begin
        // DEPTH is a power of two, so the MSB of the count is set only when full.
        full       = count_q[AW];
        push       = wr_i & ~full & ~flush_i;
        overflow_d = wr_i & full & ~flush_i;
        pop        = 1'b0;
        fired_d    = 1'b0;
        missed_d   = 1'b0;

        if (state_q == StArmed && enable_i && !flush_i) begin
            if (trig_i) begin
                pop     = 1'b1;
                fired_d = 1'b1;
            end else if (pps_i) begin
                pop      = 1'b1;
                missed_d = 1'b1;
            end
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end

        // New head may be the word being written this cycle (queue was or becomes empty).
        if (push && rd_ptr_d == wr_ptr_q) begin
            head_d = wr_time_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        trig_time_d = (count_d != '0) ? head_d : trig_time_q;

        state_d = state_q;
        if (flush_i || !enable_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (count_q != '0) state_d = StWait;
                end
                StWait: begin
                    if (pps_i) state_d = StArmed;
                end
                StArmed: begin
                    if (trig_i) begin
                        state_d = (count_d != '0) ? StWait : StIdle;
                    end else if (pps_i) begin
                        // The next head arms at this same PPS edge.
                        state_d = (count_d != '0) ? StArmed : StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            trig_time_q <= '0;
            fired_q     <= 1'b0;
            missed_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            trig_time_q <= trig_time_d;
            fired_q     <= fired_d;
            missed_q    <= missed_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk250_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_time_i;
        end
    end

    // Decoded from the state register, so an asynchronous reset drops it immediately.
    assign trig_en_o   = (state_q == StArmed);
    assign trig_time_o = trig_time_q;
    assign fired_o     = fired_q;
    assign missed_o    = missed_q;
    assign overflow_o  = overflow_q;
    assign count_o     = count_q;

endmodule
